ccc_lock_sequencer: RTL and testbench
=====================================

Name: ccc_lock_sequencer

Overview:
- Parametrised clock/reset sequencer placed directly behind a fabric CCC/PLL instance.
- Synchronises and filters the PLL LOCK, drives the global-buffer enable for the gated clock, and releases NUM_CH channel resets in a staggered order.
- Generates NUM_CH programmable clock-enable strobes and counts lock-loss events.
- Adds lock filtering, reset sequencing and divided enables that the bare CCC wrapper does not provide.

Parameters:
NUM_CH, 4, number of downstream channels (resets and clock enables), 1..8
DIV_W, 16, width of each per-channel divide value
LOCK_FILT, 64, consecutive synchronised-lock cycles required before declaring lock, >=2
STAGE_GAP, 16, cycles between successive channel reset releases, >=1

Ports:
CLK  in  1  system clock (CCC GL0 domain)
RESET  in  1  reset; one clock; reset is synchronous and active-high
PLL_LOCK  in  1  raw CCC LOCK, asynchronous to CLK
CH_EN  in  NUM_CH  per-channel enable for CE generation
DIV  in  NUM_CH*DIV_W  per-channel divide value; channel i in bits [i*DIV_W +: DIV_W]
LOCKED  out  1  filtered lock; high in RELEASE and RUN
GL_EN  out  1  enable for the gated global clock buffer (GCLKINT EN)
RST_N_OUT  out  NUM_CH  per-channel active-low reset
CE  out  NUM_CH  per-channel clock-enable strobe
LOCK_LOSS_CNT  out  8  saturating count of lock-loss events

Behaviour:
- Reset values: LOCKED=0, GL_EN=0, RST_N_OUT=all 0, CE=all 0, LOCK_LOSS_CNT=0, state=IDLE, all counters 0.
- RESET asserted mid-operation returns every output to its reset value on the next edge, including LOCK_LOSS_CNT.
- PLL_LOCK passes through a 2-flop synchroniser to give lk_s; only lk_s is used downstream.
- FSM states: IDLE, FILTER, RELEASE, RUN.
- IDLE: when lk_s=1, go to FILTER with filt_cnt=0.
- FILTER: filt_cnt increments while lk_s=1. When filt_cnt=LOCK_FILT-1, go to RELEASE with stage_cnt=0. If lk_s=0, go to IDLE; this is not counted as a loss.
- RELEASE: stage_cnt increments each cycle.
  - RST_N_OUT[i] goes high on the cycle stage_cnt reaches STAGE_GAP*(i+1)-1 and stays high.
  - On release of the last channel, go to RUN.
- RUN: holds while lk_s=1.
- Lock loss: lk_s=0 in RELEASE or RUN causes, on the next edge:
  - state=IDLE;
  - LOCKED=0, GL_EN=0, RST_N_OUT=all 0, CE=all 0;
  - LOCK_LOSS_CNT increments, saturating at 255.
- LOCKED and GL_EN are registered and high exactly while state is RELEASE or RUN. GL_EN therefore rises STAGE_GAP cycles before RST_N_OUT[0].
- Latency: PLL_LOCK held high from sample edge 0 gives LOCKED=1 after edge LOCK_FILT+2, and RST_N_OUT[i]=1 a further STAGE_GAP*(i+1) cycles later.
- CE generation, channel i: an active channel has RST_N_OUT[i]=1 and CH_EN[i]=1.
  - div_cnt[i] counts 0..DIV[i], then wraps to 0.
  - CE[i]=1 on the cycle div_cnt[i]=DIV[i], giving period DIV[i]+1.
  - DIV[i]=0 gives CE[i] continuously high.
  - When inactive: div_cnt[i] is held at 0 and CE[i]=0.
  - The first CE arrives DIV[i]+1 cycles after activation.
- A DIV[i] change is sampled only at wrap (div_cnt=0). The current period completes with the old value.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- RESET 4 cycles, PLL_LOCK=1 held (defaults) -> LOCKED and GL_EN rise at cycle 66 after the first sample; RST_N_OUT rises at +16, +32, +48, +64 cycles; LOCK_LOSS_CNT=0.
- PLL_LOCK high 40 cycles, low 1 cycle, then high -> no LOCKED during the glitch; filter restarts; LOCKED rises 66 cycles after the re-rise; LOCK_LOSS_CNT=0.
- In RUN, CH_EN=4'b1111, DIV0=0, DIV1=1, DIV2=4, DIV3=9 -> CE0 constant 1; CE1 every 2 cycles; CE2 every 5 cycles; CE3 every 10 cycles; CE1 first strobe 2 cycles after enable.
- In RUN, change DIV2 from 4 to 2 mid-period -> current 5-cycle period completes, then strobes every 3 cycles.
- In RUN, drop PLL_LOCK for 3 cycles -> 3 cycles later (sync delay + 1) all RST_N_OUT=0, CE=0, LOCKED=0, GL_EN=0; LOCK_LOSS_CNT=1; full resequence after lock returns.
- 300 lock-loss events from RUN -> LOCK_LOSS_CNT saturates at 255. Assert RESET in RELEASE -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ccc_lock_sequencer.sv
// ---------------------------------------------------------------------------
// ccc_lock_sequencer
//
// Sits directly behind a fabric CCC/PLL. It synchronises and filters the raw
// PLL LOCK, enables the gated global clock buffer once lock is trusted,
// releases the per-channel resets one after another, produces a divided
// clock-enable strobe per channel and counts how often lock was lost.
//
// Ports
//   CLK            system clock (CCC GL0 domain)
//   RESET          synchronous, active-high reset
//   PLL_LOCK       raw CCC LOCK, asynchronous to CLK
//   CH_EN          per-channel enable for CE generation
//   DIV            per-channel divide value, channel i in [i*DIV_W +: DIV_W]
//   LOCKED         filtered lock, high in RELEASE and RUN
//   GL_EN          enable for the gated global buffer (same timing as LOCKED)
//   RST_N_OUT      per-channel active-low reset, released in staggered order
//   CE             per-channel clock-enable strobe, period DIV[i]+1
//   LOCK_LOSS_CNT  saturating count of lock losses seen in RELEASE or RUN
// ---------------------------------------------------------------------------
module ccc_lock_sequencer #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int LOCK_FILT = 64,
    parameter int STAGE_GAP = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    PLL_LOCK,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    output logic                    LOCKED,
    output logic                    GL_EN,
    output logic [NUM_CH-1:0]       RST_N_OUT,
    output logic [NUM_CH-1:0]       CE,
    output logic [7:0]              LOCK_LOSS_CNT
);

    localparam int FILT_W  = $clog2(LOCK_FILT);
    // Counter must hold STAGE_GAP*NUM_CH (one past the last release point).
    localparam int STAGE_W = $clog2(STAGE_GAP * NUM_CH + 1);

    localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILT - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(STAGE_GAP * NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILTER  = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // LOCK synchroniser: two flops, only lk_s is used downstream.
    // -----------------------------------------------------------------------
    logic lk_meta_q;
    logic lk_s_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= PLL_LOCK;
            lk_s_q    <= lk_meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencing FSM
    // -----------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [FILT_W-1:0]   filt_cnt_q,  filt_cnt_d;
    logic [STAGE_W-1:0]  stage_cnt_q, stage_cnt_d;
    logic [NUM_CH-1:0]   rst_n_q,     rst_n_d;
    logic [7:0]          loss_cnt_q,  loss_cnt_d;
    logic                locked_q,    locked_d;
    logic                gl_en_q,     gl_en_d;
    logic                lock_loss;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            filt_cnt_q  <= '0;
            stage_cnt_q <= '0;
            rst_n_q     <= '0;
            loss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            gl_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            filt_cnt_q  <= filt_cnt_d;
            stage_cnt_q <= stage_cnt_d;
            rst_n_q     <= rst_n_d;
            loss_cnt_q  <= loss_cnt_d;
            locked_q    <= locked_d;
            gl_en_q     <= gl_en_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        filt_cnt_d  = filt_cnt_q;
        stage_cnt_d = stage_cnt_q;
        rst_n_d     = rst_n_q;
        loss_cnt_d  = loss_cnt_q;
        lock_loss   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lk_s_q) begin
                    state_d    = ST_FILTER;
                    filt_cnt_d = '0;
                end
            end

            ST_FILTER: begin
                // Dropping out of the filter is a failed acquisition, not a
                // loss of an established lock, so it is not counted.
                if (!lk_s_q) begin
                    state_d = ST_IDLE;
                end else if (filt_cnt_q == FILT_LAST) begin
                    state_d     = ST_RELEASE;
                    stage_cnt_d = '0;
                end else begin
                    filt_cnt_d = filt_cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!lk_s_q) begin
                    lock_loss = 1'b1;
                end else begin
                    stage_cnt_d = stage_cnt_q + 1'b1;
                    // Channel i is released when the counter reaches the end
                    // of its own gap window; released channels stay released.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (stage_cnt_q == STAGE_W'(STAGE_GAP * (i + 1) - 1)) begin
                            rst_n_d[i] = 1'b1;
                        end
                    end
                    if (stage_cnt_q == STAGE_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (!lk_s_q) begin
                    lock_loss = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (lock_loss) begin
            state_d = ST_IDLE;
            rst_n_d = '0;
            if (loss_cnt_q != 8'hFF) begin
                loss_cnt_d = loss_cnt_q + 8'd1;
            end
        end

        // Registered from the next state so LOCKED/GL_EN line up exactly
        // with the RELEASE/RUN interval.
        locked_d = (state_d == ST_RELEASE) || (state_d == ST_RUN);
        gl_en_d  = locked_d;
    end

    // -----------------------------------------------------------------------
    // Per-channel clock-enable dividers
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] ce_vec;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_in;
            logic [DIV_W-1:0] div_use;
            logic [DIV_W-1:0] div_lat_q, div_lat_d;
            logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
            logic             ce_q,      ce_d;
            logic             active;

            assign div_in = DIV[gi*DIV_W +: DIV_W];

            always_comb begin
                active    = rst_n_q[gi] & CH_EN[gi];
                // A new divide value only takes effect at the start of a
                // period (counter at zero); mid-period the latched value is
                // used so the running period finishes unchanged.
                div_use   = (div_cnt_q == '0) ? div_in : div_lat_q;
                div_lat_d = div_lat_q;
                div_cnt_d = '0;
                ce_d      = 1'b0;

                if (active && !lock_loss) begin
                    if (div_cnt_q == '0) begin
                        div_lat_d = div_in;
                    end
                    if (div_cnt_q == div_use) begin
                        div_cnt_d = '0;
                        ce_d      = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    div_lat_q <= '0;
                    div_cnt_q <= '0;
                    ce_q      <= 1'b0;
                end else begin
                    div_lat_q <= div_lat_d;
                    div_cnt_q <= div_cnt_d;
                    ce_q      <= ce_d;
                end
            end

            assign ce_vec[gi] = ce_q;
        end
    endgenerate

    assign LOCKED        = locked_q;
    assign GL_EN         = gl_en_q;
    assign RST_N_OUT     = rst_n_q;
    assign CE            = ce_vec;
    assign LOCK_LOSS_CNT = loss_cnt_q;

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccc_lock_sequencer
//
// Self-checking bench for ccc_lock_sequencer with default parameters. The
// reference model describes behaviour in terms of how long the synchronised
// lock has been continuously high and when each channel's next strobe is due.
// ---------------------------------------------------------------------------
module tb_ccc_lock_sequencer;

    localparam int NUM_CH    = 4;
    localparam int DIV_W     = 16;
    localparam int LOCK_FILT = 64;
    localparam int STAGE_GAP = 16;
    localparam int LOCK_AT   = LOCK_FILT + 1;               // lock run length that declares lock
    localparam int RUN_AT    = LOCK_AT + STAGE_GAP * NUM_CH; // run length when all channels released
    localparam int VW        = 2 + 2 * NUM_CH + 8;

    logic                    CLK = 1'b0;
    logic                    RESET = 1'b1;
    logic                    PLL_LOCK = 1'b0;
    logic [NUM_CH-1:0]       CH_EN = '0;
    logic [NUM_CH*DIV_W-1:0] DIV = '0;
    logic                    LOCKED;
    logic                    GL_EN;
    logic [NUM_CH-1:0]       RST_N_OUT;
    logic [NUM_CH-1:0]       CE;
    logic [7:0]              LOCK_LOSS_CNT;

    ccc_lock_sequencer #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .LOCK_FILT (LOCK_FILT),
        .STAGE_GAP (STAGE_GAP)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .PLL_LOCK      (PLL_LOCK),
        .CH_EN         (CH_EN),
        .DIV           (DIV),
        .LOCKED        (LOCKED),
        .GL_EN         (GL_EN),
        .RST_N_OUT     (RST_N_OUT),
        .CE            (CE),
        .LOCK_LOSS_CNT (LOCK_LOSS_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic              m_s1 = 1'b0, m_s2 = 1'b0;
    int                m_run = 0;     // consecutive edges with synchronised lock high
    logic              m_locked = 1'b0;
    logic [NUM_CH-1:0] m_rst = '0;
    logic [NUM_CH-1:0] m_ce = '0;
    int                m_cnt = 0;
    int                m_edge = 0;
    int                m_due [NUM_CH];
    bit                m_fresh [NUM_CH];

    wire  [VW-1:0] dut_vec = {LOCKED, GL_EN, RST_N_OUT, CE, LOCK_LOSS_CNT};
    logic [VW-1:0] mdl_vec;
    assign mdl_vec = {m_locked, m_locked, m_rst, m_ce, 8'(m_cnt)};

    // Advance one clock: update the model at the rising edge (inputs are
    // stable, driven on the falling edge) and return on the falling edge.
    task automatic tick();
        logic              lk;
        logic              loss;
        logic [NUM_CH-1:0] old_rst;
        @(posedge CLK);
        m_edge++;
        if (RESET) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_run = 0; m_locked = 1'b0;
            m_rst = '0; m_ce = '0; m_cnt = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_fresh[i] = 1'b1;
                m_due[i]   = 0;
            end
        end else begin
            lk      = m_s2;
            loss    = !lk && m_locked;
            old_rst = m_rst;
            for (int i = 0; i < NUM_CH; i++) begin
                if (loss || !(old_rst[i] && CH_EN[i])) begin
                    m_ce[i]    = 1'b0;
                    m_fresh[i] = 1'b1;
                end else begin
                    if (m_fresh[i]) begin
                        m_due[i]   = m_edge + int'(DIV[i*DIV_W +: DIV_W]);
                        m_fresh[i] = 1'b0;
                    end
                    if (m_edge == m_due[i]) begin
                        m_ce[i]    = 1'b1;
                        m_fresh[i] = 1'b1;
                    end else begin
                        m_ce[i] = 1'b0;
                    end
                end
            end
            if (!lk) begin
                if (loss && m_cnt < 255) m_cnt++;
                m_run = 0;
            end else begin
                m_run++;
            end
            m_locked = (m_run >= LOCK_AT);
            for (int i = 0; i < NUM_CH; i++) begin
                m_rst[i] = (m_run >= LOCK_AT + STAGE_GAP * (i + 1));
            end
            m_s2 = m_s1;
            m_s1 = PLL_LOCK;
        end
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int first_lock;
        int first_rst [NUM_CH];
        RESET = 1'b1; PLL_LOCK = 1'b1; CH_EN = '0; DIV = '0;
        repeat (4) tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", dut_vec);
        end
        RESET = 1'b0;
        first_lock = -1;
        for (int i = 0; i < NUM_CH; i++) first_rst[i] = -1;
        for (int k = 0; k <= RUN_AT + 5; k++) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL startup cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
            if (LOCKED === 1'b1 && first_lock < 0) first_lock = k;
            for (int i = 0; i < NUM_CH; i++)
                if (RST_N_OUT[i] === 1'b1 && first_rst[i] < 0) first_rst[i] = k;
        end
        checks++;
        if (first_lock != LOCK_FILT + 2) begin
            errors++; $display("FAIL lock_latency: got %0d expected %0d", first_lock, LOCK_FILT + 2);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (first_rst[i] != LOCK_FILT + 2 + STAGE_GAP * (i + 1)) begin
                errors++; $display("FAIL rst_release ch%0d: got %0d expected %0d", i, first_rst[i],
                                   LOCK_FILT + 2 + STAGE_GAP * (i + 1));
            end
        end
        checks++;
        if (LOCK_LOSS_CNT !== 8'd0) begin
            errors++; $display("FAIL startup_loss_cnt: got %0d expected 0", LOCK_LOSS_CNT);
        end
    endtask

    task automatic test_glitch();
        int  first_lock;
        bit  early_lock;
        RESET = 1'b1; PLL_LOCK = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        early_lock = 1'b0;
        repeat (40) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL glitch_pre: got %h expected %h", dut_vec, mdl_vec);
            end
            if (LOCKED !== 1'b0) early_lock = 1'b1;
        end
        PLL_LOCK = 1'b0;
        tick();
        if (LOCKED !== 1'b0) early_lock = 1'b1;
        PLL_LOCK = 1'b1;
        first_lock = -1;
        for (int k = 0; k < LOCK_FILT + 10; k++) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL glitch_post cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
            if (k < LOCK_FILT + 2 && LOCKED !== 1'b0) early_lock = 1'b1;
            if (LOCKED === 1'b1 && first_lock < 0) first_lock = k;
        end
        checks++;
        if (early_lock) begin
            errors++; $display("FAIL glitch_early_lock: got 1 expected 0");
        end
        checks++;
        if (first_lock != LOCK_FILT + 2) begin
            errors++; $display("FAIL glitch_relock_latency: got %0d expected %0d", first_lock, LOCK_FILT + 2);
        end
        checks++;
        if (LOCK_LOSS_CNT !== 8'd0) begin
            errors++; $display("FAIL glitch_loss_cnt: got %0d expected 0", LOCK_LOSS_CNT);
        end
    endtask

    task automatic test_ce_divide();
        int cnt [NUM_CH];
        int first1;
        int guard;
        guard = 0;
        while (m_run < RUN_AT && guard < 300) begin
            tick(); guard++;
        end
        checks++;
        if (m_run < RUN_AT || RST_N_OUT !== '1) begin
            errors++; $display("FAIL reach_run: got rst %b expected 1111", RST_N_OUT);
        end
        DIV = {16'd9, 16'd4, 16'd1, 16'd0};
        CH_EN = '1;
        for (int i = 0; i < NUM_CH; i++) cnt[i] = 0;
        first1 = -1;
        for (int k = 0; k < 60; k++) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL ce_model cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
            for (int i = 0; i < NUM_CH; i++) if (CE[i] === 1'b1) cnt[i]++;
            if (CE[1] === 1'b1 && first1 < 0) first1 = k;
        end
        checks++;
        if (cnt[0] != 60) begin errors++; $display("FAIL ce0_count: got %0d expected 60", cnt[0]); end
        checks++;
        if (cnt[1] != 30) begin errors++; $display("FAIL ce1_count: got %0d expected 30", cnt[1]); end
        checks++;
        if (cnt[2] != 12) begin errors++; $display("FAIL ce2_count: got %0d expected 12", cnt[2]); end
        checks++;
        if (cnt[3] != 6) begin errors++; $display("FAIL ce3_count: got %0d expected 6", cnt[3]); end
        checks++;
        if (first1 != 1) begin errors++; $display("FAIL ce1_first: got %0d expected 1", first1); end
    endtask

    task automatic test_div_change();
        logic [12:0] seen;
        int guard;
        guard = 0;
        while (CE[2] !== 1'b1 && guard < 20) begin
            tick(); guard++;
        end
        checks++;
        if (CE[2] !== 1'b1) begin
            errors++; $display("FAIL ce2_strobe_wait: got 0 expected 1");
        end
        seen = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL divchg_model cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
            seen[k] = CE[2];
            if (k == 2) DIV[2*DIV_W +: DIV_W] = 16'd2;   // mid-period change
        end
        checks++;
        if (seen !== 13'b0_1001_0010_0000) begin
            errors++; $display("FAIL divchg_strobes: got %b expected %b", seen, 13'b0_1001_0010_0000);
        end
    endtask

    task automatic test_random_ce();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 7) == 0) CH_EN[i] = ~CH_EN[i];
                if ($urandom_range(0, 9) == 0) DIV[i*DIV_W +: DIV_W] = 16'($urandom_range(0, 6));
            end
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL random_ce cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        CH_EN = '1;
    endtask

    task automatic test_lock_loss();
        int first_unlock;
        first_unlock = -1;
        PLL_LOCK = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 2) PLL_LOCK = 1'b1;   // low for three sample edges
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL loss_model cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
            if (LOCKED === 1'b0 && first_unlock < 0) begin
                first_unlock = k;
                checks++;
                if ({GL_EN, RST_N_OUT, CE} !== '0) begin
                    errors++; $display("FAIL loss_outputs: got %b expected 0", {GL_EN, RST_N_OUT, CE});
                end
            end
        end
        checks++;
        if (first_unlock != 2) begin
            errors++; $display("FAIL loss_latency: got %0d expected 2", first_unlock);
        end
        checks++;
        if (LOCK_LOSS_CNT !== 8'd1) begin
            errors++; $display("FAIL loss_cnt: got %0d expected 1", LOCK_LOSS_CNT);
        end
        for (int k = 0; k < RUN_AT + 10; k++) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL resequence cyc %0d: got %h expected %h", k, dut_vec, mdl_vec);
            end
        end
        checks++;
        if (RST_N_OUT !== '1 || LOCKED !== 1'b1) begin
            errors++; $display("FAIL resequence_done: got rst %b locked %b expected 1111 1", RST_N_OUT, LOCKED);
        end
    endtask

    task automatic test_saturation();
        int guard;
        int bad;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            guard = 0;
            while (m_run < RUN_AT && guard < 300) begin
                tick(); guard++;
                if (dut_vec !== mdl_vec) bad++;
            end
            if (m_run < RUN_AT) bad++;
            PLL_LOCK = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                tick();
                if (dut_vec !== mdl_vec) bad++;
            end
            PLL_LOCK = 1'b1;
            repeat (4) begin
                tick();
                if (dut_vec !== mdl_vec) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL saturation_model: got %0d mismatching cycles expected 0", bad);
        end
        checks++;
        if (LOCK_LOSS_CNT !== 8'd255) begin
            errors++; $display("FAIL loss_cnt_saturate: got %0d expected 255", LOCK_LOSS_CNT);
        end
    endtask

    task automatic test_reset_in_release();
        int guard;
        guard = 0;
        while (m_run != LOCK_AT + STAGE_GAP + 4 && guard < 300) begin
            tick(); guard++;
        end
        checks++;
        if (LOCKED !== 1'b1 || RST_N_OUT[0] !== 1'b1 || RST_N_OUT[NUM_CH-1] !== 1'b0) begin
            errors++; $display("FAIL reach_release: got locked %b rst %b expected 1 0001", LOCKED, RST_N_OUT);
        end
        RESET = 1'b1;
        tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_in_release: got %h expected 0", dut_vec);
        end
        RESET = 1'b0;
        repeat (10) begin
            tick();
            checks++;
            if (dut_vec !== mdl_vec) begin
                errors++; $display("FAIL post_reset: got %h expected %h", dut_vec, mdl_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_ce_divide();
        test_div_change();
        test_random_ce();
        test_lock_loss();
        test_saturation();
        test_reset_in_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
